// File: rtl/bf8b_pkg.sv
// Shared definitions for the bf8b fetch/decode slice: instruction width,
// default address width, fetch FSM state encodings and opcode constants.
package bf8b_pkg;

    localparam int INST_W     = 16;
    localparam int DEF_ADDR_W = 8;

    // Fetch FSM state encodings, kept as plain constants so legacy code that
    // compares raw 2-bit values keeps working.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE     = 2'd0;
    localparam fetch_state_t ST_FETCH_HI = 2'd1;
    localparam fetch_state_t ST_FETCH_LO = 2'd2;
    localparam fetch_state_t ST_HOLD     = 2'd3;

    // Opcode field (inst[15:12]) values shared with decode.
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LODI = 4'b0001;
    localparam logic [3:0] OP_LOD  = 4'b0010;
    localparam logic [3:0] OP_STO  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b0110;
    localparam logic [3:0] OP_JZ   = 4'b0111;

endpackage

// File: rtl/fetch_timeout.sv
// Wait-cycle counter for the instruction fetch unit. Counts consecutive
// cycles spent waiting for mem_ack and flags a timeout on the cycle the
// limit is reached. Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,      // FSM is waiting on a memory read
    input  logic ack,       // memory read completed this cycle
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // wait_cnt holds the number of wait cycles already elapsed, so the
    // limit is hit on the edge that would complete the last allowed one.
    assign timeout = busy && !ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count wait cycles; any ack, idle period or timeout restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!busy || ack || timeout) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: reads 16-bit big-endian instructions as two byte
// reads from program memory, presents them to decode with a valid/taken
// handshake, owns the program counter and handles jump redirects.
// Optional memory-wait timeout with sticky fetch_err: define FETCH_TIMEOUT_EN.
module inst_fetch
    import bf8b_pkg::*;
#(
    parameter int                ADDR_W         = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int                TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              mem_ack,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_taken,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    fetch_state_t state;
    logic [7:0]   hi_byte;
    logic         timeout;

`ifdef FETCH_TIMEOUT_EN
    logic fetch_busy;

    assign fetch_busy = (state == ST_FETCH_HI) || (state == ST_FETCH_LO);

    fetch_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fetch_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy    (fetch_busy),
        .ack     (mem_ack),
        .timeout (timeout)
    );

    // Sticky error flag; a jump on the same edge takes priority over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err <= 1'b0;
        end else if (timeout && !jump) begin
            fetch_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign fetch_err          = 1'b0;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    // Fetch FSM: jump beats timeout beats normal sequencing.
    // NOTE: every register here is assigned with <= so all updates see the
    // pre-edge values, e.g. mem_addr<=pc in HOLD uses pc as of this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hi_byte    <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
        end else if (jump) begin
            pc         <= jump_addr;
            mem_req    <= 1'b0;
            inst_valid <= 1'b0;
            state      <= ST_IDLE;
        end else if (timeout) begin
            // pc is untouched so a retry refetches the same instruction.
            mem_req <= 1'b0;
            state   <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        state    <= ST_FETCH_HI;
                    end
                end
                ST_FETCH_HI: begin
                    if (mem_ack) begin
                        hi_byte  <= mem_data;
                        mem_addr <= pc + ADDR_W'(1);
                        state    <= ST_FETCH_LO;
                    end
                end
                ST_FETCH_LO: begin
                    if (mem_ack) begin
                        inst       <= {hi_byte, mem_data};
                        inst_valid <= 1'b1;
                        mem_req    <= 1'b0;
                        pc         <= pc + ADDR_W'(2);
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (inst_taken) begin
                        inst_valid <= 1'b0;
                        if (en) begin
                            // Back-to-back: next request leaves on the same edge.
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                            state    <= ST_FETCH_HI;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed sequences with a byte-wide memory model,
// expected instructions pushed to a queue and checked by a handshake monitor.
// Build with FETCH_TIMEOUT_EN defined to include the timeout sequence.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_taken;
    logic        jump;
    logic [7:0]  jump_addr;
    logic [7:0]  pc;
    logic        fetch_err;

    logic [7:0]  mem [256];
    logic        ack_on;
    logic [15:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    inst_fetch #(
        .ADDR_W         (8),
        .RESET_PC       (8'h00),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_taken (inst_taken),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles);
        int n = 0;
        while (!inst_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_valid", inst_valid, 1'b1);
    endtask

    // Memory model: answers an outstanding request during the following cycle.
    always @(negedge clk) begin
        mem_ack  = mem_req && ack_on;
        mem_data = mem_ack ? mem[mem_addr] : 8'h00;
    end

    // Scoreboard monitor: compares each instruction as decode accepts it.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_taken && !jump) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {16'h0, inst}, 32'hFFFF_FFFF);
            end else begin
                check("sb_inst", {16'h0, inst}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] saved_pc;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
        mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
        mem[8'h04] = 8'h9A; mem[8'h05] = 8'hBC;
        mem[8'hFF] = 8'hAB;

        rst_n = 1'b0; en = 1'b0; inst_taken = 1'b0; jump = 1'b0;
        jump_addr = 8'h00; ack_on = 1'b1; mem_ack = 1'b0; mem_data = 8'h00;
        #12;
        check("rst_mem_req",    mem_req,    1'b0);
        check("rst_mem_addr",   mem_addr,   8'h00);
        check("rst_inst",       inst,       16'h0000);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_pc",         pc,         8'h00);
        check("rst_fetch_err",  fetch_err,  1'b0);
        rst_n = 1'b1;
        tick();

        // First instruction: valid three cycles after en rises.
        en = 1'b1;
        exp_q.push_back(16'h1234);
        tick();
        check("f1_req",  mem_req,  1'b1);
        check("f1_addr0", mem_addr, 8'h00);
        tick();
        check("f1_addr1", mem_addr, 8'h01);
        check("f1_not_valid_yet", inst_valid, 1'b0);
        tick();
        check("f1_valid", inst_valid, 1'b1);
        check("f1_inst",  inst,       16'h1234);
        check("f1_pc",    pc,         8'h02);
        check("f1_req_low", mem_req,  1'b0);
        tick();
        check("hold_valid", inst_valid, 1'b1);
        check("hold_inst",  inst,       16'h1234);

        // Taken with en=1: no bubble, next request on the same edge.
        inst_taken = 1'b1;
        exp_q.push_back(16'h5678);
        tick();
        inst_taken = 1'b0;
        check("b2b_valid_low", inst_valid, 1'b0);
        check("b2b_req",       mem_req,    1'b1);
        check("b2b_addr",      mem_addr,   8'h02);
        tick();
        tick();
        check("f2_inst", inst, 16'h5678);
        check("f2_pc",   pc,   8'h04);

        // en drops during FETCH_HI: instruction still completes.
        inst_taken = 1'b1;
        exp_q.push_back(16'h9ABC);
        tick();
        inst_taken = 1'b0;
        en = 1'b0;
        tick();
        tick();
        check("en0_valid", inst_valid, 1'b1);
        check("en0_inst",  inst,       16'h9ABC);
        inst_taken = 1'b1;
        tick();
        inst_taken = 1'b0;
        check("en0_idle_valid", inst_valid, 1'b0);
        check("en0_idle_req",   mem_req,    1'b0);
        tick();
        check("en0_stay_req", mem_req, 1'b0);
        check("en0_pc",       pc,      8'h06);

        // Jump during FETCH_LO with mem_ack in the same cycle.
        en = 1'b1;
        tick();
        tick();
        check("jmp_in_lo_addr", mem_addr, 8'h07);
        jump = 1'b1; jump_addr = 8'hFF;
        exp_q.push_back(16'hAB12);
        tick();
        jump = 1'b0;
        check("jmp_pc",     pc,         8'hFF);
        check("jmp_req",    mem_req,    1'b0);
        check("jmp_valid",  inst_valid, 1'b0);
        tick();
        check("jmp_fetch_addr", mem_addr, 8'hFF);
        tick();
        check("wrap_addr", mem_addr, 8'h00);
        tick();
        check("wrap_inst", inst, 16'hAB12);
        check("wrap_pc",   pc,   8'h01);
        inst_taken = 1'b1;
        en = 1'b0;
        tick();
        inst_taken = 1'b0;

        // Asynchronous reset in FETCH_LO.
        en = 1'b1;
        tick();
        tick();
        check("prerst_addr", mem_addr, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req",    mem_req,    1'b0);
        check("arst_mem_addr",   mem_addr,   8'h00);
        check("arst_inst",       inst,       16'h0000);
        check("arst_inst_valid", inst_valid, 1'b0);
        check("arst_pc",         pc,         8'h00);
        #2;
        rst_n = 1'b1;

        // Restart from RESET_PC after reset.
        exp_q.push_back(16'h1234);
        wait_valid(10);
        check("restart_pc", pc, 8'h02);
        inst_taken = 1'b1;
        en = 1'b0;
        tick();
        inst_taken = 1'b0;
        tick();

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: timeout after 15 wait cycles.
        ack_on = 1'b0;
        saved_pc = pc;
        en = 1'b1;
        tick();
        en = 1'b0;
        check("to_req", mem_req, 1'b1);
        repeat (14) tick();
        check("to_not_yet", fetch_err, 1'b0);
        check("to_req_held", mem_req, 1'b1);
        tick();
        check("to_err",  fetch_err, 1'b1);
        check("to_req0", mem_req,   1'b0);
        check("to_pc",   pc,        saved_pc);
        ack_on = 1'b1;
        tick();
        check("to_sticky", fetch_err, 1'b1);
`else
        saved_pc = pc;
        check("no_to_err", fetch_err, 1'b0);
        check("no_to_pc",  pc,        saved_pc);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Producer side of the decode interface: fetches 16-bit instructions from 8-bit-wide program memory as two byte reads, big-endian.
- Presents each assembled instruction to decode with a valid/taken handshake.
- Owns the program counter and handles jump redirects.
- Sits between program memory and decode; `inst_valid` drives decode's `en`.

Parameters:
- ADDR_W, 8, program-memory byte address width; pc width.
- RESET_PC, 0, pc value after reset.
- TIMEOUT_CYCLES, 15, max cycles waiting for `mem_ack` (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  fetch enable; 0 stops fetching after the current instruction.
- mem_req  output  1  memory read request; held until acked.
- mem_addr  output  ADDR_W  byte address; stable while `mem_req`=1.
- mem_data  input  8  read data; valid in the cycle `mem_ack`=1.
- mem_ack  input  1  one-cycle read completion strobe.
- inst  output  16  assembled instruction: {byte@pc, byte@pc+1}.
- inst_valid  output  1  `inst` valid; held until taken.
- inst_taken  input  1  consumer accepts `inst` (sampled only when `inst_valid`=1).
- jump  input  1  redirect request.
- jump_addr  input  ADDR_W  redirect target.
- pc  output  ADDR_W  address of the next instruction to fetch.
- fetch_err  output  1  sticky timeout flag (only with FETCH_TIMEOUT_EN).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC.
  - mem_req=0, mem_addr=0, inst=16'h0000, inst_valid=0, fetch_err=0.
- State machine: IDLE, FETCH_HI, FETCH_LO, HOLD.
- IDLE: if en=1 → mem_req<=1, mem_addr<=pc, go FETCH_HI.
- FETCH_HI: on mem_ack → hi byte<=mem_data, mem_addr<=pc+1 (mem_req stays 1), go FETCH_LO.
- FETCH_LO: on mem_ack → inst<={hi,mem_data}, inst_valid<=1, mem_req<=0, pc<=pc+2, go HOLD.
- HOLD:
  - inst and inst_valid are held stable.
  - On inst_taken → inst_valid<=0.
  - If en=1 at that edge → mem_req<=1, mem_addr<=pc, go FETCH_HI; else go IDLE.
- Latency: without memory stalls, inst_valid rises 3 cycles after en rises in IDLE, given mem_ack one cycle after each request.
- Address arithmetic is modulo 2^ADDR_W:
  - Instruction at 8'hFF reads its low byte from 8'h00.
  - pc 8'hFE+2 = 8'h00; pc 8'hFF+2 = 8'h01.
- en=0 mid-fetch: the current instruction completes; the FSM stops in HOLD/IDLE.
- jump=1 (highest priority, any state):
  - pc<=jump_addr, mem_req<=0, inst_valid<=0, go IDLE.
  - Any mem_ack or inst_taken in the same cycle is ignored.
  - Fetch at jump_addr starts next cycle if en=1.
- mem_ack outside FETCH_HI/FETCH_LO is ignored.
- inst_taken outside HOLD is ignored.
- Simultaneous inst_taken and en in HOLD: no bubble cycle; mem_req rises on the same edge that inst_valid falls.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on each new request/ack and counts cycles in FETCH_HI/FETCH_LO without mem_ack.
  - On reaching TIMEOUT_CYCLES: fetch_err<=1 (sticky until reset), mem_req<=0, go IDLE, pc unchanged, so a retry refetches the same instruction.
- Undefined: no counter; fetch_err is tied to 0; the FSM waits indefinitely for mem_ack.

Decomposition:
- Shared package bf8b_pkg:
  - INST_W=16, ADDR_W default.
  - Fetch state enum.
  - Opcode constants (OP_LODI=4'b0001 etc.) shared with decode.
- One sub-module: fetch_timeout (counter + compare), instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset, en=1, memory holds 8'h12@0 and 8'h34@1, mem_ack one cycle after req → inst=16'h1234, inst_valid=1 at cycle 3, pc=8'h02.
- HOLD with inst_taken=1 and en=1 → inst_valid falls, mem_req rises with mem_addr=8'h02 on the same edge; a second instruction from 8'h02/8'h03 follows.
- jump=1 with jump_addr=8'hFF while in FETCH_LO, mem_ack asserted same cycle → data discarded; next inst = {mem[FF],mem[00]}, pc=8'h01 afterwards.
- en=0 during FETCH_HI → instruction completes and is delivered; after taken, FSM returns to IDLE and mem_req stays 0.
- rst_n low mid FETCH_LO → all outputs return to reset values immediately, asynchronously; pc=RESET_PC.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, mem_ack never asserted → fetch_err=1 after 15 wait cycles, mem_req=0, pc unchanged.
